// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-lite response codes and bridge state encoding
package axi_lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW_W,
        ST_B,
        ST_RSP
    } bridge_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Anything but OKAY is reported upstream as an error, EXOKAY included.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_24110015_Reg.sv
// rtl/ysyx_24110015_Reg.sv - load-enabled register with synchronous active-high reset
module ysyx_24110015_Reg #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/axi_lite_master_bridge.sv
// rtl/axi_lite_master_bridge.sv - single-beat request port to AXI-lite initiator, one transaction in flight
module axi_lite_master_bridge
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,

    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,

    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,

    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,

    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int STRB_W = DATA_W / 8;

    bridge_state_e state_q, state_d;

    logic              req_hs;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              wen_q;

    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    logic              rsp_load;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every bus valid is a function of state and done flags only, never of a ready.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_wen ? ST_AW_W : ST_AR;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_d = ST_RSP;
                end
            end
            ST_AW_W: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                // A channel still pending completes this cycle exactly when its ready is high.
                if ((aw_done_q || awready) && (w_done_q || wready)) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_hs = req_valid && (state_q == ST_IDLE);

    ysyx_24110015_Reg #(.WIDTH(ADDR_W)) u_addr_reg (
        .clk (clk), .rst (rst), .din (req_addr), .dout (addr_q), .wen (req_hs)
    );
    ysyx_24110015_Reg #(.WIDTH(DATA_W)) u_wdata_reg (
        .clk (clk), .rst (rst), .din (req_wdata), .dout (wdata_q), .wen (req_hs)
    );
    ysyx_24110015_Reg #(.WIDTH(STRB_W)) u_wstrb_reg (
        .clk (clk), .rst (rst), .din (req_wstrb), .dout (wstrb_q), .wen (req_hs)
    );
    ysyx_24110015_Reg #(.WIDTH(1)) u_wen_reg (
        .clk (clk), .rst (rst), .din (req_wen), .dout (wen_q), .wen (req_hs)
    );

    // Done flags only live inside AW_W, so they fall back to 0 before the next write.
    assign aw_done_d = (state_q == ST_AW_W) && (aw_done_q || awready);
    assign w_done_d  = (state_q == ST_AW_W) && (w_done_q || wready);

    ysyx_24110015_Reg #(.WIDTH(1)) u_aw_done_reg (
        .clk (clk), .rst (rst), .din (aw_done_d), .dout (aw_done_q), .wen (1'b1)
    );
    ysyx_24110015_Reg #(.WIDTH(1)) u_w_done_reg (
        .clk (clk), .rst (rst), .din (w_done_d), .dout (w_done_q), .wen (1'b1)
    );

    assign rsp_load    = wen_q ? ((state_q == ST_B) && bvalid)
                               : ((state_q == ST_R) && rvalid);
    assign rsp_rdata_d = wen_q ? '0 : rdata;
    assign rsp_err_d   = resp_is_err(wen_q ? bresp : rresp);

    ysyx_24110015_Reg #(.WIDTH(DATA_W)) u_rsp_rdata_reg (
        .clk (clk), .rst (rst), .din (rsp_rdata_d), .dout (rsp_rdata), .wen (rsp_load)
    );
    ysyx_24110015_Reg #(.WIDTH(1)) u_rsp_err_reg (
        .clk (clk), .rst (rst), .din (rsp_err_d), .dout (rsp_err), .wen (rsp_load)
    );

    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// tb/tb_axi_lite_master_bridge.sv - scoreboard bench with behavioural slave memory and reference model
module tb_axi_lite_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_wen;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] araddr, awaddr;
    logic          arvalid, arready, rvalid, rready, awvalid, awready;
    logic          wvalid, wready, bvalid, bready;
    logic [DW-1:0] rdata, wdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    rresp, bresp;

    axi_lite_master_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_wen (req_wen),
        .req_addr (req_addr), .req_wdata (req_wdata), .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .araddr (araddr), .arvalid (arvalid), .arready (arready),
        .rdata (rdata), .rresp (rresp), .rvalid (rvalid), .rready (rready),
        .awaddr (awaddr), .awvalid (awvalid), .awready (awready),
        .wdata (wdata), .wstrb (wstrb), .wvalid (wvalid), .wready (wready),
        .bresp (bresp), .bvalid (bvalid), .bready (bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;
    rsp_t sb_q[$];

    // Reference model: a word-addressed memory; the top two 256MB regions answer with an error.
    logic [31:0] model_mem [logic [29:0]];
    logic [31:0] slave_mem [logic [29:0]];

    function automatic logic [31:0] init_word(input logic [29:0] idx);
        return {idx[15:0], ~idx[15:0]} ^ 32'h5a5a_0000;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a[31:2]) ? model_mem[a[31:2]] : init_word(a[31:2]);
    endfunction

    function automatic logic model_err(input logic [31:0] a);
        return a >= 32'hE000_0000;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = model_read(a);
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        model_mem[a[31:2]] = w;
    endtask

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return slave_mem.exists(a[31:2]) ? slave_mem[a[31:2]] : init_word(a[31:2]);
    endfunction

    function automatic logic [1:0] slave_resp(input logic [31:0] a);
        case (a[31:28])
            4'hE:    return 2'b10;
            4'hF:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        model_mem[a[31:2]] = d;
        slave_mem[a[31:2]] = d;
    endtask

    // Slave wait knobs and per-transaction observations shared between driver and environment.
    int ar_w, r_w, aw_w, w_w, b_w, rsp_w, k_r, k_b;
    bit r_pend, b_pend, got_aw, got_w, ready_chk;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wstrb;
    int n_ar_hs, n_aw_hs, n_w_hs, n_arv, n_awv, n_wv, first_v, rsp_cyc, resp_cnt = 0;

    // Slave and response monitor; acts 1 time unit after each falling edge.
    initial begin
        arready = 0; rvalid = 0; rdata = '0; rresp = '0; awready = 0; wready = 0;
        bvalid = 0; bresp = '0; rsp_ready = 0;
        r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0; ready_chk = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; rsp_ready = 0;
                r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0; ready_chk = 0;
            end else begin
                if (ready_chk) begin
                    check("req_ready_after_rsp", req_ready, 1);
                    ready_chk = 0;
                end
                rvalid = r_pend && (r_w == 0);
                if (r_pend && r_w > 0) r_w--;
                if (rvalid && rready) r_pend = 0;
                bvalid = b_pend && (b_w == 0);
                if (b_pend && b_w > 0) b_w--;
                if (bvalid && bready) b_pend = 0;

                arready = (ar_w == 0);
                if (arvalid) begin
                    n_arv++;
                    if (first_v < 0) first_v = cyc;
                    check("araddr_stable", araddr, cur_addr);
                    if (arready) begin
                        n_ar_hs++;
                        r_pend = 1; r_w = k_r;
                        rdata = slave_rd(araddr); rresp = slave_resp(araddr);
                    end else ar_w--;
                end
                awready = (aw_w == 0);
                if (awvalid) begin
                    n_awv++;
                    if (first_v < 0) first_v = cyc;
                    check("awaddr_stable", awaddr, cur_addr);
                    if (awready) begin n_aw_hs++; got_aw = 1; s_awaddr = awaddr; end
                    else aw_w--;
                end
                wready = (w_w == 0);
                if (wvalid) begin
                    n_wv++;
                    if (first_v < 0) first_v = cyc;
                    check("wdata_stable", wdata, cur_wdata);
                    check("wstrb_stable", wstrb, cur_wstrb);
                    if (wready) begin n_w_hs++; got_w = 1; s_wdata = wdata; s_wstrb = wstrb; end
                    else w_w--;
                end
                if (got_aw && got_w) begin
                    got_aw = 0; got_w = 0;
                    b_pend = 1; b_w = k_b;
                    bresp = slave_resp(s_awaddr);
                    if (bresp == 2'b00) begin
                        logic [31:0] w;
                        w = slave_rd(s_awaddr);
                        for (int i = 0; i < 4; i++) if (s_wstrb[i]) w[8*i +: 8] = s_wdata[8*i +: 8];
                        slave_mem[s_awaddr[31:2]] = w;
                    end
                end

                rsp_ready = (rsp_w == 0);
                if (rsp_valid) begin
                    check("no_req_ready_in_rsp", req_ready, 0);
                    if (rsp_cyc < 0) rsp_cyc = cyc;
                    check("sb_nonempty", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        check("rsp_rdata", rsp_rdata, sb_q[0].rdata);
                        check("rsp_err", rsp_err, sb_q[0].err);
                        if (rsp_ready) begin
                            void'(sb_q.pop_front());
                            resp_cnt++;
                            ready_chk = 1;
                        end else rsp_w--;
                    end
                end
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_ctrl"}, {arvalid, rready, awvalid, wvalid, bready, rsp_valid, req_ready}, 7'b0000001);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
    endtask

    task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int d_ar, input int d_r, input int d_aw,
                           input int d_w, input int d_b, input int d_rsp, input int abort);
        rsp_t e;
        int   t, t0, n0;
        bit   zl;
        t = 0;
        while (!req_ready && t < 100) begin @(negedge clk); t++; end
        check("req_ready_wait", req_ready, 1);
        cur_addr = addr; cur_wdata = wd; cur_wstrb = ws;
        k_r = d_r; k_b = d_b; ar_w = d_ar; aw_w = d_aw; w_w = d_w; rsp_w = d_rsp;
        n_ar_hs = 0; n_aw_hs = 0; n_w_hs = 0; n_arv = 0; n_awv = 0; n_wv = 0;
        first_v = -1; rsp_cyc = -1;
        zl = (d_ar + d_r + d_aw + d_w + d_b) == 0;
        if (abort == 0) begin
            e.err = model_err(addr);
            if (wen) begin
                e.rdata = '0;
                if (!e.err) model_write(addr, wd, ws);
            end else e.rdata = model_read(addr);
            sb_q.push_back(e);
        end
        req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        t0 = cyc; n0 = resp_cnt;
        @(negedge clk);
        req_valid = 0; req_wen = $urandom_range(0, 1); req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = 4'($urandom);
        if (abort > 0) begin
            repeat (abort) @(negedge clk);
            check("abort_aw_done", n_aw_hs, 1);
            check("abort_w_pending", n_w_hs, 0);
            rst = 1;
            @(negedge clk);
            rst = 0;
            check_idle("after_abort");
            return;
        end
        t = 0;
        while (resp_cnt == n0 && t < 200) begin @(negedge clk); t++; end
        check("rsp_count", resp_cnt - n0, 1);
        if (resp_cnt == n0) begin
            rst = 1; @(negedge clk); rst = 0; sb_q.delete();
            return;
        end
        if (zl) begin
            check("lat_first_valid", first_v - t0, 1);
            check("lat_rsp_valid", rsp_cyc - t0, 3);
        end
        if (wen) begin
            check("aw_hs_once", n_aw_hs, 1);
            check("w_hs_once", n_w_hs, 1);
            check("no_ar_on_write", n_ar_hs, 0);
            check("awvalid_cycles", n_awv, d_aw + 1);
            check("wvalid_cycles", n_wv, d_w + 1);
        end else begin
            check("ar_hs_once", n_ar_hs, 1);
            check("no_aw_w_on_read", n_aw_hs + n_w_hs, 0);
            check("arvalid_cycles", n_arv, d_ar + 1);
        end
    endtask

    logic [31:0] bases [4] = '{32'h8000_0000, 32'hA000_0000, 32'hE000_0000, 32'hF000_0000};

    initial begin
        rst = 1; req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        ar_w = 0; aw_w = 0; w_w = 0; rsp_w = 0; k_r = 0; k_b = 0; first_v = -1; rsp_cyc = -1;
        cur_addr = '0; cur_wdata = '0; cur_wstrb = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        check_idle("reset");

        poke(32'hA000_0048, 32'h1234_5678);
        run_txn(0, 32'hA000_0048, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        run_txn(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 3, 0, 0, 0, 0);
        run_txn(0, 32'h8000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        run_txn(0, 32'hF000_0010, 32'h0, 4'h0, 0, 1, 0, 0, 0, 0, 0);
        run_txn(1, 32'hE000_0020, 32'h1111_2222, 4'hF, 0, 0, 0, 0, 2, 0, 0);
        run_txn(0, 32'hA000_0048, 32'h0, 4'h0, 5, 0, 0, 0, 0, 3, 0);
        run_txn(1, 32'h8000_0020, 32'hCAFE_F00D, 4'h5, 0, 0, 0, 0, 0, 0, 0);
        run_txn(0, 32'h8000_0020, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1, 0);
        run_txn(1, 32'h8000_0030, 32'h5555_AAAA, 4'hF, 0, 0, 0, 20, 0, 0, 3);
        run_txn(0, 32'h8000_0030, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        run_txn(0, 32'h8000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = bases[$urandom_range(0, 3)] + ($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
            run_txn($urandom_range(0, 1), a, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
